// File: rtl/lsu.sv
// lsu: load/store stage between execute and writeback.
//   Captures the execute result on the upstream valid/ready handshake. ALU ops
//   pass through in one cycle. Loads/stores issue one request on the 64-bit
//   data port, wait for the ack pulse, then present the aligned/extended result.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_pre_valid/o_pre_ready      upstream handshake, i_pre_nop marks a bubble
//   o_post_valid/i_post_ready    downstream handshake
//   i_exu_*, s_exu_diffpc        execute-stage fields (res is the address for mem ops)
//   o_mem_*, i_mem_ack/rdata     data-memory request/response
//   o_lsu_*, s_lsu_*             writeback value, dest reg, simulation tags
module lsu #(
  parameter int W  = 64,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pre_nop,
  input  logic          i_pre_valid,
  output logic          o_pre_ready,
  output logic          o_post_valid,
  input  logic          i_post_ready,
  input  logic [W-1:0]  i_exu_res,
  input  logic [W-1:0]  i_exu_rs2,
  input  logic [2:0]    i_exu_lsfunc3,
  input  logic          i_exu_lden,
  input  logic          i_exu_sten,
  input  logic          i_exu_ldstbp,
  input  logic [AW-1:0] i_exu_rdid,
  input  logic          i_exu_rdwen,
  input  logic [W-1:0]  s_exu_diffpc,
  output logic          o_mem_req,
  output logic          o_mem_wen,
  output logic          o_mem_uncached,
  output logic [W-1:0]  o_mem_addr,
  output logic [W-1:0]  o_mem_wdata,
  output logic [7:0]    o_mem_wmask,
  input  logic          i_mem_ack,
  input  logic [W-1:0]  i_mem_rdata,
  output logic [W-1:0]  o_lsu_res,
  output logic [AW-1:0] o_lsu_rdid,
  output logic          o_lsu_rdwen,
  output logic [W-1:0]  s_lsu_diffpc,
  output logic          s_lsu_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic          valid_r;
  logic [W-1:0]  res_r, rs2_r, diffpc_r, ld_val_r;
  logic [2:0]    func3_r;
  logic          lden_r, sten_r, ldstbp_r, rdwen_r;
  logic [AW-1:0] rdid_r;

  logic          pre_sh, in_mem;
  logic [2:0]    off;
  logic [W-1:0]  sh, ld_val;
  logic [7:0]    mask_base;
  logic [3:0]    size;

  // A bubble never counts as a memory op, whatever lden/sten say.
  assign in_mem = (i_exu_lden | i_exu_sten) & ~i_pre_nop;

  assign o_pre_ready = ((state == S_IDLE) & (~valid_r | i_post_ready))
                     | ((state == S_RESP) & i_post_ready);
  assign pre_sh      = i_pre_valid & o_pre_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      valid_r  <= 1'b0;
      res_r    <= '0;
      rs2_r    <= '0;
      diffpc_r <= '0;
      ld_val_r <= '0;
      func3_r  <= '0;
      lden_r   <= 1'b0;
      sten_r   <= 1'b0;
      ldstbp_r <= 1'b0;
      rdwen_r  <= 1'b0;
      rdid_r   <= '0;
    end else begin
      if (pre_sh) begin
        res_r    <= i_exu_res;
        rs2_r    <= i_exu_rs2;
        func3_r  <= i_exu_lsfunc3;
        ldstbp_r <= i_exu_ldstbp;
        lden_r   <= i_exu_lden  & ~i_pre_nop;
        sten_r   <= i_exu_sten  & ~i_pre_nop;
        rdwen_r  <= i_exu_rdwen & ~i_pre_nop;
        rdid_r   <= i_pre_nop ? '0 : i_exu_rdid;
        diffpc_r <= i_pre_nop ? W'(1) : s_exu_diffpc;
      end
      case (state)
        S_IDLE: begin
          if (pre_sh) begin
            state   <= in_mem ? S_REQ : S_IDLE;
            valid_r <= ~in_mem;
          end else if (i_post_ready) begin
            valid_r <= 1'b0;
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            ld_val_r <= ld_val;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_post_ready) begin
            // pre_sh here implies the result is being consumed this cycle.
            state   <= (pre_sh & in_mem) ? S_REQ : S_IDLE;
            valid_r <= pre_sh & ~in_mem;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign off  = res_r[2:0];
  assign size = 4'd1 << func3_r[1:0];
  assign sh   = i_mem_rdata >> {off, 3'b000};

  always_comb begin
    ld_val = sh;
    case (func3_r)
      3'b000:  ld_val = {{(W-8){sh[7]}},   sh[7:0]};
      3'b001:  ld_val = {{(W-16){sh[15]}}, sh[15:0]};
      3'b010:  ld_val = {{(W-32){sh[31]}}, sh[31:0]};
      3'b100:  ld_val = {{(W-8){1'b0}},    sh[7:0]};
      3'b101:  ld_val = {{(W-16){1'b0}},   sh[15:0]};
      3'b110:  ld_val = {{(W-32){1'b0}},   sh[31:0]};
      default: ld_val = sh;
    endcase
  end

  always_comb begin
    mask_base = 8'h01;
    case (func3_r[1:0])
      2'b00:   mask_base = 8'h01;
      2'b01:   mask_base = 8'h03;
      2'b10:   mask_base = 8'h0F;
      default: mask_base = 8'hFF;
    endcase
  end

  // Request fields come straight from the input register, which cannot change
  // while in REQ (o_pre_ready is low), so they stay stable until the ack.
  assign o_mem_req      = (state == S_REQ);
  assign o_mem_wen      = sten_r & ~lden_r;
  assign o_mem_uncached = ldstbp_r;
  assign o_mem_addr     = {res_r[W-1:3], 3'b000};
  assign o_mem_wdata    = rs2_r << {off, 3'b000};
  // Bytes shifted past bit 7 are dropped: misaligned stores are truncated.
  assign o_mem_wmask    = o_mem_wen ? (mask_base << off) : 8'h00;

  assign s_lsu_misalign = (state == S_REQ) & (({2'b00, off} + {1'b0, size}) > 5'd8);

  assign o_post_valid = (state == S_IDLE) ? valid_r : (state == S_RESP);
  assign o_lsu_res    = lden_r ? ld_val_r : res_r;
  assign o_lsu_rdid   = rdid_r;
  assign o_lsu_rdwen  = rdwen_r;
  assign s_lsu_diffpc = diffpc_r;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios with literal expectations, then random
// traffic (random ready/ack/reset) checked every cycle against a
// transaction-level model of the stage.
module tb_lsu;
  logic        i_clk = 1'b0;
  logic        i_rst, i_pre_nop, i_pre_valid, i_post_ready;
  logic [63:0] i_exu_res, i_exu_rs2, s_exu_diffpc, i_mem_rdata;
  logic [2:0]  i_exu_lsfunc3;
  logic        i_exu_lden, i_exu_sten, i_exu_ldstbp, i_exu_rdwen, i_mem_ack;
  logic [4:0]  i_exu_rdid;
  logic        o_pre_ready, o_post_valid, o_mem_req, o_mem_wen, o_mem_uncached;
  logic [63:0] o_mem_addr, o_mem_wdata, o_lsu_res, s_lsu_diffpc;
  logic [7:0]  o_mem_wmask;
  logic [4:0]  o_lsu_rdid;
  logic        o_lsu_rdwen, s_lsu_misalign;

  lsu #(.W(64), .AW(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pre_nop(i_pre_nop), .i_pre_valid(i_pre_valid),
    .o_pre_ready(o_pre_ready), .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
    .i_exu_res(i_exu_res), .i_exu_rs2(i_exu_rs2), .i_exu_lsfunc3(i_exu_lsfunc3),
    .i_exu_lden(i_exu_lden), .i_exu_sten(i_exu_sten), .i_exu_ldstbp(i_exu_ldstbp),
    .i_exu_rdid(i_exu_rdid), .i_exu_rdwen(i_exu_rdwen), .s_exu_diffpc(s_exu_diffpc),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_uncached(o_mem_uncached),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_lsu_res(o_lsu_res),
    .o_lsu_rdid(o_lsu_rdid), .o_lsu_rdwen(o_lsu_rdwen), .s_lsu_diffpc(s_lsu_diffpc),
    .s_lsu_misalign(s_lsu_misalign)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Model: at most one instruction held; a memory op is "done" once acked.
  logic        m_live = 1'b0;
  logic        m_hold, m_mem, m_ld, m_st, m_acked, m_bp, m_rdwen;
  logic [63:0] m_res, m_rs2, m_pc, m_ldval;
  logic [2:0]  m_f3;
  logic [4:0]  m_rdid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] ld_model(input logic [2:0] f3, input int off, input logic [63:0] rd);
    logic [63:0] v = '0;
    int sz = size_of(f3);
    for (int i = 0; i < sz; i++)
      if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && sz < 8 && v[8*sz-1])
      for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] mask_model(input logic [2:0] f3, input int off);
    logic [7:0] m = '0;
    for (int b = 0; b < 8; b++) m[b] = (b >= off) && (b < off + size_of(f3));
    return m;
  endfunction

  function automatic logic [63:0] wdata_model(input logic [63:0] d, input int off);
    logic [63:0] w = '0;
    for (int b = 0; b < 8; b++) if (b >= off) w[8*b +: 8] = d[8*(b-off) +: 8];
    return w;
  endfunction

  function automatic logic m_done();
    return !m_mem || m_acked;
  endfunction

  function automatic logic m_ready();
    return !m_hold || (m_done() && i_post_ready);
  endfunction

  task automatic mcheck();
    logic req, pv, wen;
    int off;
    if (!m_live) return;
    off = int'(m_res[2:0]);
    req = m_hold && m_mem && !m_acked;
    pv  = m_hold && m_done();
    wen = m_st && !m_ld;
    chk("pre_ready", 64'(o_pre_ready), 64'(m_ready()));
    chk("mem_req", 64'(o_mem_req), 64'(req));
    chk("post_valid", 64'(o_post_valid), 64'(pv));
    if (req) begin
      chk("mem_addr", o_mem_addr, m_res & ~64'h7);
      chk("mem_wen", 64'(o_mem_wen), 64'(wen));
      chk("mem_uncached", 64'(o_mem_uncached), 64'(m_bp));
      chk("mem_wmask", 64'(o_mem_wmask), wen ? 64'(mask_model(m_f3, off)) : 64'h0);
      chk("misalign", 64'(s_lsu_misalign), 64'(off + size_of(m_f3) > 8));
      if (wen) chk("mem_wdata", o_mem_wdata, wdata_model(m_rs2, off));
    end
    if (pv) begin
      chk("lsu_res", o_lsu_res, m_ld ? m_ldval : m_res);
      chk("lsu_rdid", 64'(o_lsu_rdid), 64'(m_rdid));
      chk("lsu_rdwen", 64'(o_lsu_rdwen), 64'(m_rdwen));
      chk("lsu_diffpc", s_lsu_diffpc, m_pc);
    end
  endtask

  // Uses the inputs as they were at the clock edge (they change only at negedge).
  task automatic mupdate();
    logic done, sh;
    if (i_rst) begin
      m_live = 1'b1; m_hold = 0; m_mem = 0; m_ld = 0; m_st = 0; m_acked = 0;
      m_bp = 0; m_rdwen = 0; m_res = 0; m_rs2 = 0; m_pc = 0; m_ldval = 0;
      m_f3 = 0; m_rdid = 0;
      return;
    end
    if (!m_live) return;
    done = m_done();
    sh   = i_pre_valid && m_ready();
    if (m_hold && m_mem && !m_acked && i_mem_ack) begin
      m_acked = 1'b1;
      m_ldval = ld_model(m_f3, int'(m_res[2:0]), i_mem_rdata);
    end
    if (m_hold && done && i_post_ready) m_hold = 1'b0;
    if (sh) begin
      m_hold  = 1'b1;
      m_acked = 1'b0;
      m_ld    = i_exu_lden && !i_pre_nop;
      m_st    = i_exu_sten && !i_pre_nop;
      m_mem   = m_ld || m_st;
      m_res   = i_exu_res;
      m_rs2   = i_exu_rs2;
      m_f3    = i_exu_lsfunc3;
      m_bp    = i_exu_ldstbp;
      m_rdwen = i_exu_rdwen && !i_pre_nop;
      m_rdid  = i_pre_nop ? 5'd0 : i_exu_rdid;
      m_pc    = i_pre_nop ? 64'd1 : s_exu_diffpc;
    end
  endtask

  task automatic cyc_start();
    #1;
    mcheck();
  endtask

  task automatic cyc_end();
    @(posedge i_clk);
    mupdate();
    @(negedge i_clk);
  endtask

  task automatic quiet();
    i_rst = 0; i_pre_nop = 0; i_pre_valid = 0; i_post_ready = 1; i_mem_ack = 0;
    i_exu_lden = 0; i_exu_sten = 0; i_exu_ldstbp = 0; i_exu_rdwen = 0;
  endtask

  // Issue one load with ack in the first REQ cycle; return the RESP result.
  task automatic run_load(input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rd, output logic [63:0] res);
    quiet();
    i_pre_valid = 1; i_exu_lden = 1; i_exu_lsfunc3 = f3; i_exu_res = addr;
    i_exu_rdid = 5'd7; i_exu_rdwen = 1; s_exu_diffpc = 64'h100;
    cyc_start(); cyc_end();
    quiet(); i_mem_ack = 1; i_mem_rdata = rd;
    cyc_start();
    chk("ld_req", 64'(o_mem_req), 64'd1);
    chk("ld_addr", o_mem_addr, addr & ~64'h7);
    cyc_end();
    quiet();
    cyc_start();
    chk("ld_post_valid", 64'(o_post_valid), 64'd1);
    res = o_lsu_res;
    cyc_end();
  endtask

  logic [63:0] r;

  initial begin
    quiet();
    i_rst = 1; i_exu_res = 0; i_exu_rs2 = 0; s_exu_diffpc = 0; i_mem_rdata = 0;
    i_exu_lsfunc3 = 0; i_exu_rdid = 0;
    @(negedge i_clk);
    cyc_start(); cyc_end();
    cyc_start(); cyc_end();

    // Reset state
    quiet();
    cyc_start();
    chk("rst_post_valid", 64'(o_post_valid), 64'd0);
    chk("rst_pre_ready", 64'(o_pre_ready), 64'd1);
    chk("rst_mem_req", 64'(o_mem_req), 64'd0);
    chk("rst_mem_wen", 64'(o_mem_wen), 64'd0);
    chk("rst_wmask", 64'(o_mem_wmask), 64'd0);
    chk("rst_misalign", 64'(s_lsu_misalign), 64'd0);
    chk("rst_res", o_lsu_res, 64'd0);
    chk("rst_diffpc", s_lsu_diffpc, 64'd0);
    cyc_end();

    // ALU pass-through, back to back
    i_pre_valid = 1; i_exu_res = 64'h1234; i_exu_rdid = 5; i_exu_rdwen = 1;
    cyc_start(); cyc_end();
    i_exu_res = 64'h5678; i_exu_rdid = 6;
    cyc_start();
    chk("alu_valid", 64'(o_post_valid), 64'd1);
    chk("alu_res", o_lsu_res, 64'h1234);
    chk("alu_rdid", 64'(o_lsu_rdid), 64'd5);
    chk("alu_ready", 64'(o_pre_ready), 64'd1);
    cyc_end();
    quiet();
    cyc_start();
    chk("alu2_res", o_lsu_res, 64'h5678);
    chk("alu2_valid", 64'(o_post_valid), 64'd1);
    cyc_end();
    cyc_start(); chk("alu_drained", 64'(o_post_valid), 64'd0); cyc_end();

    // Signed / unsigned byte load
    run_load(3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, r);
    chk("lb_res", r, 64'hFFFF_FFFF_FFFF_FF80);
    run_load(3'b100, 64'h8000_0003, 64'h0000_0000_8000_0000, r);
    chk("lbu_res", r, 64'h80);

    // Halfword store at offset 6
    quiet();
    i_pre_valid = 1; i_exu_sten = 1; i_exu_lsfunc3 = 3'b001; i_exu_res = 64'h1006;
    i_exu_rs2 = 64'hABCD; i_exu_rdwen = 0;
    cyc_start(); cyc_end();
    quiet(); i_mem_ack = 1;
    cyc_start();
    chk("sh_wen", 64'(o_mem_wen), 64'd1);
    chk("sh_wmask", 64'(o_mem_wmask), 64'hC0);
    chk("sh_wdata", o_mem_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_misalign", 64'(s_lsu_misalign), 64'd0);
    cyc_end();
    quiet();
    cyc_start(); chk("sh_rdwen", 64'(o_lsu_rdwen), 64'd0); cyc_end();

    // Wait states then backpressure
    quiet();
    i_pre_valid = 1; i_exu_lden = 1; i_exu_lsfunc3 = 3'b011; i_exu_res = 64'h2000_0010;
    cyc_start(); cyc_end();
    quiet();
    for (int k = 0; k < 3; k++) begin
      cyc_start();
      chk("ws_req", 64'(o_mem_req), 64'd1);
      chk("ws_ready", 64'(o_pre_ready), 64'd0);
      chk("ws_addr", o_mem_addr, 64'h2000_0010);
      cyc_end();
    end
    i_mem_ack = 1; i_mem_rdata = 64'h1122_3344_5566_7788;
    cyc_start(); cyc_end();
    quiet(); i_post_ready = 0; i_mem_rdata = 0;
    for (int k = 0; k < 2; k++) begin
      cyc_start();
      chk("bp_valid", 64'(o_post_valid), 64'd1);
      chk("bp_res", o_lsu_res, 64'h1122_3344_5566_7788);
      cyc_end();
    end
    i_post_ready = 1;
    cyc_start(); cyc_end();

    // Bubble carrying lden
    quiet();
    i_pre_valid = 1; i_pre_nop = 1; i_exu_lden = 1; i_exu_rdwen = 1; i_exu_rdid = 9;
    s_exu_diffpc = 64'h40;
    cyc_start(); cyc_end();
    quiet();
    cyc_start();
    chk("nop_req", 64'(o_mem_req), 64'd0);
    chk("nop_valid", 64'(o_post_valid), 64'd1);
    chk("nop_diffpc", s_lsu_diffpc, 64'd1);
    chk("nop_rdwen", 64'(o_lsu_rdwen), 64'd0);
    cyc_end();

    // Reset mid-request, late ack ignored
    quiet();
    i_pre_valid = 1; i_exu_lden = 1; i_exu_lsfunc3 = 3'b011; i_exu_res = 64'h30;
    cyc_start(); cyc_end();
    quiet(); i_rst = 1;
    cyc_start(); chk("rr_req", 64'(o_mem_req), 64'd1); cyc_end();
    quiet(); i_mem_ack = 1;
    cyc_start(); chk("rr_req_drop", 64'(o_mem_req), 64'd0); cyc_end();
    quiet();
    cyc_start(); chk("rr_no_valid", 64'(o_post_valid), 64'd0); cyc_end();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      i_rst         = ($urandom_range(0, 499) == 0);
      i_pre_valid   = ($urandom_range(0, 9) < 7);
      i_pre_nop     = ($urandom_range(0, 9) == 0);
      i_exu_lden    = $urandom_range(0, 2) == 0;
      i_exu_sten    = $urandom_range(0, 2) == 0;
      i_exu_ldstbp  = $urandom_range(0, 1);
      i_exu_lsfunc3 = 3'($urandom_range(0, 6));
      i_exu_res     = {$urandom, $urandom};
      i_exu_rs2     = {$urandom, $urandom};
      s_exu_diffpc  = {$urandom, $urandom};
      i_exu_rdid    = 5'($urandom);
      i_exu_rdwen   = $urandom_range(0, 1);
      i_post_ready  = ($urandom_range(0, 9) < 7);
      i_mem_ack     = ($urandom_range(0, 9) < 4);
      i_mem_rdata   = {$urandom, $urandom};
      cyc_start(); cyc_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
